// File: rtl/clock_pkg.sv
// Shared constants, edit-state encoding and hour/field helpers for the clock core.
package clock_pkg;

  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;

  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(59);
  localparam logic [MIN_W-1:0]  MIN_LAST  = MIN_W'(59);
  localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(23);
  localparam logic [HOUR_W-1:0] HOUR_NOON = HOUR_W'(12);

  // Edit state as seen on oEditState.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    EDIT_SEC  = 2'd1,
    EDIT_MIN  = 2'd2,
    EDIT_HOUR = 2'd3
  } editState_t;

  // 24-hour value to 12-hour display value (0 and 12 both show as 12).
  function automatic logic [HOUR_W-1:0] hour24To12(input logic [HOUR_W-1:0] hour24);
    logic [HOUR_W-1:0] hour12;
    if (hour24 == HOUR_W'(0)) begin
      hour12 = HOUR_NOON;
    end else if (hour24 > HOUR_NOON) begin
      hour12 = hour24 - HOUR_NOON;
    end else begin
      hour12 = hour24;
    end
    return hour12;
  endfunction

  // One wrapping edit step on a 0..59 field.
  function automatic logic [SEC_W-1:0] stepSixty(input logic [SEC_W-1:0] value, input logic up);
    logic [SEC_W-1:0] res;
    if (up) begin
      res = (value == SEC_LAST) ? SEC_W'(0) : value + SEC_W'(1);
    end else begin
      res = (value == SEC_W'(0)) ? SEC_LAST : value - SEC_W'(1);
    end
    return res;
  endfunction

  // One wrapping edit step on the 0..23 hour field.
  function automatic logic [HOUR_W-1:0] stepHour(input logic [HOUR_W-1:0] value, input logic up);
    logic [HOUR_W-1:0] res;
    if (up) begin
      res = (value == HOUR_LAST) ? HOUR_W'(0) : value + HOUR_W'(1);
    end else begin
      res = (value == HOUR_W'(0)) ? HOUR_LAST : value - HOUR_W'(1);
    end
    return res;
  endfunction

  // Field selection after a Left press: SEC -> MIN -> HOUR -> SEC.
  function automatic editState_t navLeft(input editState_t cur);
    editState_t nxt;
    case (cur)
      EDIT_SEC:  nxt = EDIT_MIN;
      EDIT_MIN:  nxt = EDIT_HOUR;
      EDIT_HOUR: nxt = EDIT_SEC;
      default:   nxt = cur;
    endcase
    return nxt;
  endfunction

  // Field selection after a Right press: SEC -> HOUR -> MIN -> SEC.
  function automatic editState_t navRight(input editState_t cur);
    editState_t nxt;
    case (cur)
      EDIT_SEC:  nxt = EDIT_HOUR;
      EDIT_HOUR: nxt = EDIT_MIN;
      EDIT_MIN:  nxt = EDIT_SEC;
      default:   nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Hold-to-repeat strobe generator: counts ticks while a button is held and enabled,
// strobes once after DELAY ticks and then every RATE ticks.
module btn_repeat #(
  parameter int unsigned DELAY = 50,
  parameter int unsigned RATE  = 10
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iTick,
  input  logic iEn,
  input  logic iHeld,
  output logic oStrobe
);

  localparam int unsigned CNT_MAX = DELAY + RATE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;

  assign cntNext = cnt + CNT_W'(1);

  // Tick counter folds back to DELAY once in the repeat phase, so it never exceeds DELAY+RATE.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt     <= '0;
      oStrobe <= 1'b0;
    end else begin
      oStrobe <= 1'b0;
      if (!(iEn && iHeld)) begin
        cnt <= '0;
      end else if (iTick) begin
        if (cntNext == CNT_W'(CNT_MAX)) begin
          cnt     <= CNT_W'(DELAY);
          oStrobe <= 1'b1;
        end else begin
          cnt <= cntNext;
          if (cntNext == CNT_W'(DELAY)) begin
            oStrobe <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/clock_core_gen2.sv
// Timekeeping core: sub/sec/min/hour counters, RUN/EDIT state machine with field editing,
// hold-to-repeat stepping and second/day carry pulses.
module clock_core_gen2
  import clock_pkg::*;
#(
  parameter int unsigned SUB_DIV      = 100,
  parameter int unsigned SUB_W        = $clog2(SUB_DIV),
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iTick,
  input  logic              iMode24,
  input  logic              iBtnRunStop,
  input  logic              iBtnInc,
  input  logic              iBtnDec,
  input  logic              iBtnLeft,
  input  logic              iBtnRight,
  input  logic              iIncHeld,
  input  logic              iDecHeld,
  output logic [SUB_W-1:0]  oSub,
  output logic [SEC_W-1:0]  oSec,
  output logic [MIN_W-1:0]  oMin,
  output logic [HOUR_W-1:0] oHour,
  output logic              oPm,
  output logic [1:0]        oEditState,
  output logic              oSecPulse,
  output logic              oDayPulse
);

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);

  editState_t        state;
  logic [HOUR_W-1:0] hour;
  logic              editing;
  logic              incStrobe;
  logic              decStrobe;
  logic              incStep;
  logic              decStep;

  assign editing = (state != RUN);

  // Inc wins over dec; at most one step per cycle.
  assign incStep = iBtnInc | incStrobe;
  assign decStep = ~incStep & (iBtnDec | decStrobe);

  // Display-only views of the stored 24-hour value.
  assign oHour      = iMode24 ? hour : hour24To12(hour);
  assign oPm        = (hour >= HOUR_NOON);
  assign oEditState = state;

  // Inc repeat counter.
  btn_repeat #(
    .DELAY (REPEAT_DELAY),
    .RATE  (REPEAT_RATE)
  ) uIncRepeat (
    .iClk    (iClk),
    .iRst    (iRst),
    .iTick   (iTick),
    .iEn     (editing),
    .iHeld   (iIncHeld),
    .oStrobe (incStrobe)
  );

  // Dec repeat counter; held-inc keeps it cleared so only inc auto-repeats.
  btn_repeat #(
    .DELAY (REPEAT_DELAY),
    .RATE  (REPEAT_RATE)
  ) uDecRepeat (
    .iClk    (iClk),
    .iRst    (iRst),
    .iTick   (iTick),
    .iEn     (editing),
    .iHeld   (iDecHeld & ~iIncHeld),
    .oStrobe (decStrobe)
  );

  // Time registers and edit FSM; everything is decided by the state at the start of the cycle.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oSub      <= '0;
      oSec      <= '0;
      oMin      <= '0;
      hour      <= HOUR_NOON;
      state     <= RUN;
      oSecPulse <= 1'b0;
      oDayPulse <= 1'b0;
    end else begin
      oSecPulse <= 1'b0;
      oDayPulse <= 1'b0;
      if (state == RUN) begin
        if (iTick) begin
          if (oSub == SUB_LAST) begin
            oSub      <= '0;
            oSecPulse <= 1'b1;
            if (oSec == SEC_LAST) begin
              oSec <= '0;
              if (oMin == MIN_LAST) begin
                oMin <= '0;
                if (hour == HOUR_LAST) begin
                  hour      <= '0;
                  oDayPulse <= 1'b1;
                end else begin
                  hour <= hour + HOUR_W'(1);
                end
              end else begin
                oMin <= oMin + MIN_W'(1);
              end
            end else begin
              oSec <= oSec + SEC_W'(1);
            end
          end else begin
            oSub <= oSub + SUB_W'(1);
          end
        end
        if (iBtnRunStop) begin
          state <= EDIT_SEC;
        end
      end else if (iBtnRunStop) begin
        state <= RUN;
      end else begin
        if (incStep || decStep) begin
          case (state)
            EDIT_SEC: begin
              oSec <= stepSixty(oSec, incStep);
              oSub <= '0;
            end
            EDIT_MIN:  oMin <= stepSixty(oMin, incStep);
            EDIT_HOUR: hour <= stepHour(hour, incStep);
            default: ;
          endcase
        end
        if (iBtnLeft) begin
          state <= navLeft(state);
        end else if (iBtnRight) begin
          state <= navRight(state);
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_core_gen2.sv
// Self-checking bench for clock_core_gen2: directed scenarios plus randomized stimulus
// compared cycle by cycle against a time-of-day reference model.
module tb_clock_core_gen2;

  localparam int SUB_DIV = 100;
  localparam int SUB_W   = $clog2(SUB_DIV);
  localparam int DELAY   = 50;
  localparam int RATE    = 10;
  localparam int DAY_TICKS = 86400 * SUB_DIV;

  logic             iClk;
  logic             iRst;
  logic             iTick;
  logic             iMode24;
  logic             iBtnRunStop;
  logic             iBtnInc;
  logic             iBtnDec;
  logic             iBtnLeft;
  logic             iBtnRight;
  logic             iIncHeld;
  logic             iDecHeld;
  logic [SUB_W-1:0] oSub;
  logic [5:0]       oSec;
  logic [5:0]       oMin;
  logic [4:0]       oHour;
  logic             oPm;
  logic [1:0]       oEditState;
  logic             oSecPulse;
  logic             oDayPulse;

  clock_core_gen2 #(
    .SUB_DIV      (SUB_DIV),
    .SUB_W        (SUB_W),
    .REPEAT_DELAY (DELAY),
    .REPEAT_RATE  (RATE)
  ) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iTick       (iTick),
    .iMode24     (iMode24),
    .iBtnRunStop (iBtnRunStop),
    .iBtnInc     (iBtnInc),
    .iBtnDec     (iBtnDec),
    .iBtnLeft    (iBtnLeft),
    .iBtnRight   (iBtnRight),
    .iIncHeld    (iIncHeld),
    .iDecHeld    (iDecHeld),
    .oSub        (oSub),
    .oSec        (oSec),
    .oMin        (oMin),
    .oHour       (oHour),
    .oPm         (oPm),
    .oEditState  (oEditState),
    .oSecPulse   (oSecPulse),
    .oDayPulse   (oDayPulse)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: time of day as plain integers, field index 0=run, 1=sec, 2=min, 3=hour.
  int mSub, mSec, mMin, mHour, mState;
  bit mSecP, mDayP;
  int incN, decN;
  bit incPend, decPend;
  bit mode24 = 1'b1;
  int secPulseSeen = 0;

  task automatic checkEq(input string tag, input int got, input int exp);
    nChecks++;
    if (got != exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dispHour(input int h, input bit m24);
    if (m24) return h;
    return (h % 12 == 0) ? 12 : h % 12;
  endfunction

  task automatic modelStep(input bit r, input bit t, input bit rs, input bit bi, input bit bd,
                           input bit bl, input bit br, input bit ih, input bit dh);
    bit newIncP, newDecP, up, down, editing;
    int total, f;
    if (r) begin
      mSub = 0; mSec = 0; mMin = 0; mHour = 12; mState = 0;
      mSecP = 0; mDayP = 0; incN = 0; decN = 0; incPend = 0; decPend = 0;
      return;
    end
    editing = (mState != 0);
    newIncP = 0;
    newDecP = 0;
    if (editing && ih) begin
      if (t) begin
        incN++;
        newIncP = (incN >= DELAY) && ((incN - DELAY) % RATE == 0);
      end
    end else begin
      incN = 0;
    end
    if (editing && dh && !ih) begin
      if (t) begin
        decN++;
        newDecP = (decN >= DELAY) && ((decN - DELAY) % RATE == 0);
      end
    end else begin
      decN = 0;
    end
    up   = bi || incPend;
    down = !up && (bd || decPend);
    mSecP = 0;
    mDayP = 0;
    if (mState == 0) begin
      if (t) begin
        total = (((mHour * 60 + mMin) * 60 + mSec) * SUB_DIV + mSub + 1) % DAY_TICKS;
        mSub  = total % SUB_DIV;
        mSec  = (total / SUB_DIV) % 60;
        mMin  = (total / (SUB_DIV * 60)) % 60;
        mHour = total / (SUB_DIV * 3600);
        mSecP = (mSub == 0);
        mDayP = (total == 0);
      end
      if (rs) mState = 1;
    end else if (rs) begin
      mState = 0;
    end else begin
      f = mState;
      if (up || down) begin
        case (f)
          1: begin mSec = (mSec + (up ? 1 : 59)) % 60; mSub = 0; end
          2: mMin = (mMin + (up ? 1 : 59)) % 60;
          default: mHour = (mHour + (up ? 1 : 23)) % 24;
        endcase
      end
      if (bl)      mState = (f == 3) ? 1 : f + 1;
      else if (br) mState = (f == 1) ? 3 : f - 1;
    end
    incPend = newIncP;
    decPend = newDecP;
  endtask

  // One clock: drive inputs, advance the model, sample after the edge and compare.
  task automatic step(input bit r, input bit t, input bit rs, input bit bi, input bit bd,
                      input bit bl, input bit br, input bit ih, input bit dh);
    iRst = r; iTick = t; iBtnRunStop = rs; iBtnInc = bi; iBtnDec = bd;
    iBtnLeft = bl; iBtnRight = br; iIncHeld = ih; iDecHeld = dh; iMode24 = mode24;
    modelStep(r, t, rs, bi, bd, bl, br, ih, dh);
    @(posedge iClk);
    #1;
    if (oSecPulse) secPulseSeen++;
    checkEq("sub", oSub, mSub);
    checkEq("sec", oSec, mSec);
    checkEq("min", oMin, mMin);
    checkEq("hour", oHour, dispHour(mHour, mode24));
    checkEq("pm", oPm, (mHour >= 12) ? 1 : 0);
    checkEq("state", oEditState, mState);
    checkEq("secPulse", oSecPulse, mSecP);
    checkEq("dayPulse", oDayPulse, mDayP);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic pressRs();    step(0, 0, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic pressInc(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask
  task automatic pressDec(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0, 0, 0, 0);
  endtask
  task automatic pressLeft();  step(0, 0, 0, 0, 0, 1, 0, 0, 0); endtask
  task automatic pressRight(); step(0, 0, 0, 0, 0, 0, 1, 0, 0); endtask

  initial begin
    bit ih, dh;
    iRst = 1'b1; iTick = 0; iMode24 = 1; iBtnRunStop = 0; iBtnInc = 0; iBtnDec = 0;
    iBtnLeft = 0; iBtnRight = 0; iIncHeld = 0; iDecHeld = 0;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkEq("rst_hour", oHour, 12);
    checkEq("rst_pm", oPm, 1);
    checkEq("rst_state", oEditState, 0);
    mode24 = 1'b0;
    idle(1);
    checkEq("rst_hour12", oHour, 12);
    mode24 = 1'b1;

    // One second of ticks
    secPulseSeen = 0;
    tickN(100);
    checkEq("sec_after_100", oSec, 1);
    checkEq("sub_after_100", oSub, 0);
    checkEq("secpulse_count", secPulseSeen, 1);

    // Edit to 23:59:59, run to .99, then roll the day
    pressRs();
    pressDec(2);
    pressLeft();
    pressDec(1);
    pressLeft();
    pressInc(11);
    pressRs();
    tickN(99);
    checkEq("pre_roll_hour", oHour, 23);
    tickN(1);
    checkEq("roll_secpulse", oSecPulse, 1);
    checkEq("roll_daypulse", oDayPulse, 1);
    checkEq("roll_hour", oHour, 0);
    checkEq("roll_min", oMin, 0);
    checkEq("roll_sec", oSec, 0);
    idle(1);
    checkEq("roll_daypulse_gone", oDayPulse, 0);

    // 12/24 display of hour 13
    pressRs();
    pressRight();
    pressInc(13);
    pressRs();
    mode24 = 1'b0;
    idle(1);
    checkEq("h13_12h", oHour, 1);
    checkEq("h13_pm", oPm, 1);
    mode24 = 1'b1;
    idle(1);
    checkEq("h13_24h", oHour, 13);
    checkEq("h13_min_kept", oMin, 0);

    // Hour wrap on dec, sec wrap on inc with sub clear
    tickN(5937);
    checkEq("pre_edit_sec", oSec, 59);
    checkEq("pre_edit_sub", oSub, 37);
    pressRs();
    pressLeft();
    pressLeft();
    checkEq("nav_hour", oEditState, 3);
    pressDec(13);
    pressDec(1);
    checkEq("hour_dec_wrap", oHour, 23);
    pressLeft();
    checkEq("nav_sec", oEditState, 1);
    checkEq("sub_frozen", oSub, 37);
    pressInc(1);
    checkEq("sec_inc_wrap", oSec, 0);
    checkEq("sec_edit_sub_clr", oSub, 0);
    checkEq("sec_edit_min_kept", oMin, 0);

    // Auto-repeat on minutes: inc alone, then inc with dec also held
    pressLeft();
    for (int i = 0; i < 80; i++) step(0, 1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkEq("repeat_inc_min", oMin, 4);
    for (int i = 0; i < 80; i++) step(0, 1, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkEq("repeat_both_min", oMin, 8);

    // RunStop + Inc + Tick while running
    pressRs();
    step(0, 1, 1, 1, 0, 0, 0, 0, 0);
    checkEq("rs_inc_state", oEditState, 1);
    checkEq("rs_inc_sec", oSec, 0);
    checkEq("rs_inc_sub", oSub, 1);

    // Reset in the middle of a repeat on hours
    pressRight();
    for (int i = 0; i < 59; i++) step(0, 1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkEq("mid_rst_hour", oHour, 12);
    checkEq("mid_rst_state", oEditState, 0);
    checkEq("mid_rst_sub", oSub, 0);

    // Randomized stimulus
    ih = 0;
    dh = 0;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(99) < 2) ih = !ih;
      if ($urandom_range(99) < 2) dh = !dh;
      if ($urandom_range(199) == 0) mode24 = !mode24;
      step($urandom_range(1999) == 0, $urandom_range(99) < 70, $urandom_range(99) < 1,
           $urandom_range(99) < 6, $urandom_range(99) < 6, $urandom_range(99) < 4,
           $urandom_range(99) < 4, ih, dh);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
